gc_resp_rx: RTL
===============

// Module: gc_resp_rx
// PURPOSE
// Receives the 64-bit GameCube controller response following each poll issued by the
// poll generator. Samples the shared data line once GC_enable drops. Classifies each
// bit by its low-time and presents the captured word plus a one-cycle valid strobe to
// the N64-side reply encoder. Flags malformed frames instead of passing them on.
// PARAMETERS
// BIT_THRESH   96   low-time (clk cycles) below which a bit is '1', else '0' (2us @48MHz)
// GLITCH_CYC   8    low pulses shorter than this are a frame error
// TIMEOUT_CYC  288  high or low run this long (6us @48MHz) ends or aborts the frame
// PORTS
// clk         in   1   system clock (48 MHz on pico-ice)
// rst         in   1   synchronous, active-high reset
// GC_enable   in   1   high while the poll generator drives the line; falling edge arms rx
// gc_data_in  in   1   raw GC data line (asynchronous, idle high)
// resp_data   out  64  last good response, bit 63 = first bit received
// resp_valid  out  1   one-cycle strobe: resp_data updated
// resp_error  out  1   one-cycle strobe: frame aborted, resp_data unchanged
// busy        out  1   high in ARMED, LOW, HIGH states
// BEHAVIOUR
// - Reset: resp_data=0, resp_valid=0, resp_error=0, busy=0, state=IDLE, counters=0.
//   rst has priority in any state; a frame in progress is discarded with no strobe.
// - gc_data_in passes through a 2-FF synchroniser, then an edge-detect register.
//   All timing below refers to the synchronised signal d_s.
// - GC_enable is sampled by one register. Its falling edge (1->0) is the arm event.
// - run_cnt: 9-bit, saturates at 511, and clears on every d_s edge.
// - bit_cnt: 7-bit count of bits captured (0..64).
// - shift_reg: 64-bit, shifts left with the new bit entering at LSB.
// - State IDLE: wait for the GC_enable falling edge, then go to ARMED.
//   Edges on d_s are ignored in IDLE, so the poll's own waveform is never decoded.
// - State ARMED: on a d_s falling edge go to LOW.
//   If run_cnt reaches TIMEOUT_CYC*4 (no controller), pulse resp_error and go to IDLE.
// - State LOW: on a d_s rising edge:
//   - If low time < GLITCH_CYC: error.
//   - Else if bit_cnt<64: shift in (low time < BIT_THRESH), bit_cnt++, go to HIGH.
//   - Else (bit_cnt==64, this was the stop bit): complete, go to IDLE.
//   - If low time reaches TIMEOUT_CYC (stuck low): error.
// - State HIGH: on a d_s falling edge go to LOW.
//   - If high run reaches TIMEOUT_CYC with bit_cnt==64: complete (stop bit missing is
//     tolerated).
//   - If it times out with bit_cnt<64: error.
// - Complete: resp_data<=shift_reg, resp_valid=1 for exactly one cycle, state IDLE.
//   Latency is 1 clk after the synchronised edge or timeout that completes the frame.
// - Error: resp_error=1 for one cycle, resp_data held, state IDLE, bit_cnt=0.
// - resp_valid and resp_error are never high in the same cycle.
// - A GC_enable falling edge while busy is ignored. A rising edge while busy
//   (next poll starting) aborts with resp_error.
// - bit_cnt, shift_reg and run_cnt clear on every entry to ARMED.
// TESTING
// - 64 bits of pattern 0x0080_8080_8080_8080 (1us/3us cells) + 2us stop bit
//   -> one resp_valid, resp_data=0x0080808080808080, no resp_error.
// - Same frame, stop bit omitted -> resp_valid 288 clk after the last rising edge,
//   with the same data.
// - Only 40 bits sent, then line idle high -> resp_error once, resp_data keeps its
//   prior value.
// - 0.1us low glitch (5 clk) mid-frame -> resp_error. A following good frame after
//   the next poll -> resp_valid.
// - Line held low 10us after bit 12 -> resp_error at low-run 288. rst pulsed during
//   bit 30 -> no strobes, all outputs return to reset values next cycle.
// - Poll waveform toggling while GC_enable=1 -> no decode. busy rises only after the
//   GC_enable falling edge.

Source files
------------

// File: rtl/gc_resp_rx.sv
// gc_resp_rx: decodes the 64-bit GameCube controller response and presents it with
// one-cycle valid/error strobes.
`default_nettype none

module gc_resp_rx #(
  parameter int BIT_THRESH  = 96,
  parameter int GLITCH_CYC  = 8,
  parameter int TIMEOUT_CYC = 288
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        GC_enable,
  input  logic        gc_data_in,
  output logic [63:0] resp_data,
  output logic        resp_valid,
  output logic        resp_error,
  output logic        busy
);

  localparam logic [9:0]  THRESH_L  = 10'(BIT_THRESH);
  localparam logic [9:0]  GLITCH_L  = 10'(GLITCH_CYC);
  localparam logic [9:0]  TIMEOUT_L = 10'(TIMEOUT_CYC);
  localparam logic [10:0] ARM_LAST  = 11'(TIMEOUT_CYC * 4 - 1);

  typedef enum logic [1:0] {IDLE, ARMED, LOW, HIGH} state_t;

  state_t      state, state_nx;
  logic        d_meta, d_s, d_prev, en_prev;
  logic [8:0]  run_cnt;
  logic [10:0] arm_cnt;
  logic [6:0]  bit_cnt;
  logic [63:0] shift_reg;

  logic        d_rise, d_fall, en_fall, en_rise;
  logic [9:0]  run_len;
  logic        arm_entry, complete, abort, take_bit, bit_val;

  assign d_rise  = d_s & ~d_prev;
  assign d_fall  = ~d_s & d_prev;
  assign en_fall = en_prev & ~GC_enable;
  assign en_rise = ~en_prev & GC_enable;
  // run_cnt starts at 0 in the cycle after an edge, so the run length is one more
  assign run_len = {1'b0, run_cnt} + 10'd1;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    arm_entry = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    take_bit  = 1'b0;
    bit_val   = 1'b0;
    case (state)
      IDLE: begin
        if (en_fall) begin
          state_nx  = ARMED;
          arm_entry = 1'b1;
        end
      end
      ARMED: begin
        if (en_rise)                abort = 1'b1;
        else if (d_fall)            state_nx = LOW;
        else if (arm_cnt == ARM_LAST) abort = 1'b1;
      end
      LOW: begin
        if (en_rise) begin
          abort = 1'b1;
        end else if (d_rise) begin
          if (run_len < GLITCH_L) begin
            abort = 1'b1;
          end else if (bit_cnt < 7'd64) begin
            take_bit = 1'b1;
            bit_val  = (run_len < THRESH_L);
            state_nx = HIGH;
          end else begin
            complete = 1'b1;
          end
        end else if (run_len == TIMEOUT_L) begin
          abort = 1'b1;
        end
      end
      HIGH: begin
        if (en_rise) begin
          abort = 1'b1;
        end else if (d_fall) begin
          state_nx = LOW;
        end else if (run_len == TIMEOUT_L) begin
          // a missing stop bit is tolerated once all 64 data bits are in
          if (bit_cnt == 7'd64) complete = 1'b1;
          else                  abort    = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (complete || abort) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_meta     <= 1'b1;
      d_s        <= 1'b1;
      d_prev     <= 1'b1;
      en_prev    <= 1'b0;
      run_cnt    <= '0;
      arm_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      resp_data  <= '0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
    end else begin
      d_meta     <= gc_data_in;
      d_s        <= d_meta;
      d_prev     <= d_s;
      en_prev    <= GC_enable;
      resp_valid <= complete;
      resp_error <= abort;
      if (complete) resp_data <= shift_reg;

      if (arm_entry || d_rise || d_fall) run_cnt <= '0;
      else if (run_cnt != 9'd511)        run_cnt <= run_cnt + 9'd1;

      // separate wider counter: the no-controller timeout exceeds run_cnt's range
      if (arm_entry)            arm_cnt <= '0;
      else if (state == ARMED)  arm_cnt <= arm_cnt + 11'd1;

      if (arm_entry) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
      end else if (abort) begin
        bit_cnt   <= '0;
      end else if (take_bit) begin
        bit_cnt   <= bit_cnt + 7'd1;
        shift_reg <= {shift_reg[62:0], bit_val};
      end
    end
  end

endmodule

`default_nettype wire
